// File: rtl/pipe_stage_reg_if.sv
// rtl/pipe_stage_reg_if.sv - valid/ready handshake bundle around one pipeline stage register
interface pipe_stage_reg_if #(
   parameter int PAYLOAD_W = 160
);
   logic                 in_valid;
   logic [PAYLOAD_W-1:0] in_data;
   logic                 in_ready;
   logic                 out_valid;
   logic [PAYLOAD_W-1:0] out_data;
   logic                 out_ready;

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data
   );

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data
   );
endinterface

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - ID/EX stage register with flush, bubbles and stall counter
// Define PIPE_STAGE_SKID_EN to add a second (skid) entry and a registered in_ready.
module pipe_stage_reg #(
   parameter int                   PAYLOAD_W   = 160,
   parameter logic [PAYLOAD_W-1:0] NOP_PAYLOAD = '0,
   parameter int                   CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush_i,
   pipe_stage_reg_if.slave  bus,
   output logic             discarded,
   output logic [1:0]       occupancy,
   output logic [CNT_W-1:0] stall_cnt
);

   logic                 main_valid_q, main_valid_d;
   logic [PAYLOAD_W-1:0] main_data_q,  main_data_d;
   logic                 skid_valid_q, skid_valid_d;
   logic [PAYLOAD_W-1:0] skid_data_q,  skid_data_d;
   logic                 discarded_q,  discarded_d;
   logic [1:0]           occ_q,        occ_d;
   logic [CNT_W-1:0]     stall_q,      stall_d;
   logic                 in_xfer;

`ifdef PIPE_STAGE_SKID_EN
   assign bus.in_ready = !skid_valid_q;
`else
   assign bus.in_ready = !main_valid_q || bus.out_ready;
`endif

   assign in_xfer = bus.in_valid && bus.in_ready;

   always_comb begin
      main_valid_d = main_valid_q;
      main_data_d  = main_data_q;
      skid_valid_d = skid_valid_q;
      skid_data_d  = skid_data_q;
      if (flush_i) begin
         main_valid_d = 1'b0;
         main_data_d  = NOP_PAYLOAD;
         skid_valid_d = 1'b0;
         skid_data_d  = NOP_PAYLOAD;
`ifdef PIPE_STAGE_SKID_EN
      end else if (skid_valid_q) begin
         // Skid is the older entry: it moves up before any new input lands behind it.
         if (bus.out_ready) begin
            main_valid_d = 1'b1;
            main_data_d  = skid_data_q;
            skid_valid_d = in_xfer;
            skid_data_d  = in_xfer ? bus.in_data : NOP_PAYLOAD;
         end
      end else if (!main_valid_q || bus.out_ready) begin
         main_valid_d = bus.in_valid;
         main_data_d  = bus.in_valid ? bus.in_data : NOP_PAYLOAD;
      end else if (bus.in_valid) begin
         skid_valid_d = 1'b1;
         skid_data_d  = bus.in_data;
      end
`else
      end else if (bus.in_ready) begin
         main_valid_d = bus.in_valid;
         main_data_d  = bus.in_valid ? bus.in_data : NOP_PAYLOAD;
      end
`endif
   end

   always_comb begin
      occ_d       = {1'b0, main_valid_d} + {1'b0, skid_valid_d};
      discarded_d = flush_i && (occ_q != 2'd0);
      stall_d     = stall_q;
      if (main_valid_q && !bus.out_ready && (stall_q != {CNT_W{1'b1}})) begin
         stall_d = stall_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         main_valid_q <= 1'b0;
         main_data_q  <= NOP_PAYLOAD;
         skid_valid_q <= 1'b0;
         skid_data_q  <= NOP_PAYLOAD;
         discarded_q  <= 1'b0;
         occ_q        <= 2'd0;
         stall_q      <= '0;
      end else begin
         main_valid_q <= main_valid_d;
         main_data_q  <= main_data_d;
         skid_valid_q <= skid_valid_d;
         skid_data_q  <= skid_data_d;
         discarded_q  <= discarded_d;
         occ_q        <= occ_d;
         stall_q      <= stall_d;
      end
   end

   assign bus.out_valid = main_valid_q;
   assign bus.out_data  = main_data_q;
   assign discarded     = discarded_q;
   assign occupancy     = occ_q;
   assign stall_cnt     = stall_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - vector table plus scoreboard bench for pipe_stage_reg
module tb_pipe_stage_reg;
   localparam int           W   = 160;
   localparam int           CW  = 4;
   localparam logic [W-1:0] NOP = 160'h0BAD_F00D;

   typedef struct {
      logic         iv;
      logic [W-1:0] d;
      logic         ordy;
      logic         fl;
      logic         exp_rdy;
      logic         exp_ov;
      logic [W-1:0] exp_od;
      logic [1:0]   exp_occ;
      logic         exp_disc;
   } vec_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          flush_i;
   logic          discarded;
   logic [1:0]    occupancy;
   logic [CW-1:0] stall_cnt;

   int           n_checks = 0;
   int           n_fail   = 0;
   logic [W-1:0] sb_q[$];
   vec_t         tbl[$];

   always #5 clk = ~clk;

   pipe_stage_reg_if #(.PAYLOAD_W(W)) bus ();

   pipe_stage_reg #(
      .PAYLOAD_W   (W),
      .NOP_PAYLOAD (NOP),
      .CNT_W       (CW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .flush_i   (flush_i),
      .bus       (bus),
      .discarded (discarded),
      .occupancy (occupancy),
      .stall_cnt (stall_cnt)
   );

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic iv, input logic [W-1:0] d, input logic ordy, input logic fl);
      bus.in_valid  = iv;
      bus.in_data   = d;
      bus.out_ready = ordy;
      flush_i       = fl;
   endtask

   // Scoreboard bookkeeping for the upcoming edge, then advance past it.
   task automatic tick();
      logic ix, ox;
      #1;
      ix = bus.in_valid && bus.in_ready;
      ox = bus.out_valid && bus.out_ready;
      if (!rst && ox) begin
         if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sb_underflow: got %0h expected nothing", bus.out_data);
         end else begin
            check("sb_order", bus.out_data, sb_q.pop_front());
         end
      end
      if (rst || flush_i) sb_q.delete();
      else if (ix) sb_q.push_back(bus.in_data);
      @(posedge clk);
      #1;
   endtask

   function automatic vec_t mk(input logic iv, input logic [7:0] d, input logic ordy, input logic fl,
                               input logic rdy, input logic ov, input logic [7:0] od,
                               input logic [1:0] occ, input logic disc);
      vec_t v;
      v.iv = iv; v.d = {{(W-8){1'b0}}, d}; v.ordy = ordy; v.fl = fl;
      v.exp_rdy = rdy; v.exp_ov = ov;
      v.exp_od = ov ? {{(W-8){1'b0}}, od} : NOP;
      v.exp_occ = occ; v.exp_disc = disc;
      return v;
   endfunction

   initial begin
      logic [CW-1:0] exp_stall;
`ifdef PIPE_STAGE_SKID_EN
      tbl.push_back(mk(1, 8'h01, 0, 0, 1, 1, 8'h01, 1, 0));
      tbl.push_back(mk(1, 8'h02, 0, 0, 1, 1, 8'h01, 2, 0));
      tbl.push_back(mk(1, 8'h03, 0, 0, 0, 1, 8'h01, 2, 0));
      tbl.push_back(mk(1, 8'h03, 1, 0, 0, 1, 8'h02, 1, 0));
      tbl.push_back(mk(1, 8'h03, 1, 0, 1, 1, 8'h03, 1, 0));
      tbl.push_back(mk(0, 8'h00, 1, 0, 1, 0, 8'h00, 0, 0));
      tbl.push_back(mk(1, 8'h05, 0, 0, 1, 1, 8'h05, 1, 0));
      tbl.push_back(mk(1, 8'h06, 0, 0, 1, 1, 8'h05, 2, 0));
      tbl.push_back(mk(0, 8'h00, 1, 1, 0, 0, 8'h00, 0, 1));
      tbl.push_back(mk(0, 8'h00, 1, 0, 1, 0, 8'h00, 0, 0));
      exp_stall = 4'd3;
`else
      tbl.push_back(mk(1, 8'hA5, 1, 0, 1, 1, 8'hA5, 1, 0));
      tbl.push_back(mk(1, 8'hA5, 1, 0, 1, 1, 8'hA5, 1, 0));
      tbl.push_back(mk(1, 8'h11, 1, 0, 1, 1, 8'h11, 1, 0));
      for (int i = 0; i < 5; i++) tbl.push_back(mk(1, 8'h33, 0, 0, 0, 1, 8'h11, 1, 0));
      tbl.push_back(mk(1, 8'h22, 1, 1, 1, 0, 8'h00, 0, 1));
      tbl.push_back(mk(0, 8'h00, 1, 0, 1, 0, 8'h00, 0, 0));
      tbl.push_back(mk(0, 8'h00, 1, 1, 1, 0, 8'h00, 0, 0));
      tbl.push_back(mk(1, 8'h44, 0, 0, 1, 1, 8'h44, 1, 0));
      tbl.push_back(mk(0, 8'h00, 1, 0, 1, 0, 8'h00, 0, 0));
      exp_stall = 4'd5;
`endif

      rst = 1'b1;
      drive(0, '0, 0, 0);
      tick();
      tick();
      rst = 1'b0;
      check("rst_out_valid", bus.out_valid, 1'b0);
      check("rst_out_data", bus.out_data, NOP);
      check("rst_occupancy", occupancy, 2'd0);
      check("rst_discarded", discarded, 1'b0);
      check("rst_stall_cnt", stall_cnt, '0);
      check("rst_in_ready", bus.in_ready, 1'b1);

      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i].iv, tbl[i].d, tbl[i].ordy, tbl[i].fl);
         #1;
         check($sformatf("v%0d_in_ready", i), bus.in_ready, tbl[i].exp_rdy);
         tick();
         check($sformatf("v%0d_out_valid", i), bus.out_valid, tbl[i].exp_ov);
         check($sformatf("v%0d_out_data", i), bus.out_data, tbl[i].exp_od);
         check($sformatf("v%0d_occupancy", i), occupancy, tbl[i].exp_occ);
         check($sformatf("v%0d_discarded", i), discarded, tbl[i].exp_disc);
      end
      check("table_stall_cnt", stall_cnt, exp_stall);

      rst = 1'b1;
      drive(1, 160'h99, 1, 1);
      tick();
      rst = 1'b0;
      check("rst2_stall_cnt", stall_cnt, '0);
      check("rst2_out_valid", bus.out_valid, 1'b0);

      drive(1, 160'h77, 1, 0);
      tick();
      check("load_out_data", bus.out_data, 160'h77);
      check("load_stall_cnt", stall_cnt, '0);
      drive(0, '0, 0, 0);
      for (int i = 0; i < 14; i++) tick();
      check("stall14_cnt", stall_cnt, 4'd14);
      tick();
      check("stall15_cnt", stall_cnt, 4'd15);
      for (int i = 0; i < 5; i++) tick();
      check("stall20_sat", stall_cnt, 4'd15);
      check("stall20_out_data", bus.out_data, 160'h77);
      check("stall20_occupancy", occupancy, 2'd1);
`ifndef PIPE_STAGE_SKID_EN
      check("stall20_in_ready", bus.in_ready, 1'b0);
`endif

      rst = 1'b1;
      drive(1, 160'h88, 0, 1);
      tick();
      rst = 1'b0;
      drive(0, '0, 0, 0);
      #1;
      check("midstall_rst_out_valid", bus.out_valid, 1'b0);
      check("midstall_rst_out_data", bus.out_data, NOP);
      check("midstall_rst_occupancy", occupancy, 2'd0);
      check("midstall_rst_discarded", discarded, 1'b0);
      check("midstall_rst_stall_cnt", stall_cnt, '0);
      check("midstall_rst_in_ready", bus.in_ready, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter PAYLOAD_W, default 160, width of the opaque stage payload (aluop, alusel, operands, wd, wreg, link_pc, offset concatenated).
REQ-002 SHALL have parameter NOP_PAYLOAD, default all-zero, bubble/reset payload value.
REQ-003 SHALL have parameter CNT_W, default 16, width of stall counter.
REQ-004 clk  input  1  single clock; all state updates on posedge clk.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 flush_i  input  1  discard all held entries (branch mispredict).
REQ-007 in_valid  input  1  upstream (ID) offers payload.
REQ-008 in_data  input  PAYLOAD_W  upstream payload.
REQ-009 in_ready  output  1  stage can accept; transfer when in_valid && in_ready.
REQ-010 out_valid  output  1  stage holds valid payload for EX.
REQ-011 out_data  output  PAYLOAD_W  payload to EX; equals NOP_PAYLOAD when out_valid=0.
REQ-012 out_ready  input  1  downstream consumes; transfer when out_valid && out_ready.
REQ-013 discarded  output  1  one-cycle pulse: previous cycle's flush removed >=1 valid entry.
REQ-014 occupancy  output  2  valid entries held (0..1, or 0..2 with skid).
REQ-015 stall_cnt  output  CNT_W  cycles with out_valid && !out_ready.

Function
REQ-016 Payload SHALL be presented on out_data exactly one cycle after the accepting edge when the stage was empty or draining.
REQ-017 Without skid, in_ready SHALL equal !out_valid || out_ready (combinational).
REQ-018 On an edge with in_ready=1 and no flush, main entry SHALL load in_data with out_valid=1 if in_valid, else NOP_PAYLOAD with out_valid=0 (bubble).
REQ-019 On an edge with in_ready=0 and no flush, all entries SHALL hold unchanged.
REQ-020 flush_i SHALL take priority over any same-cycle input transfer: all entries cleared to NOP_PAYLOAD/invalid, accepted in_data dropped.
REQ-021 discarded SHALL be 1 in the cycle after a flush edge where occupancy was nonzero, else 0.
REQ-022 stall_cnt SHALL increment by 1 on each edge with out_valid && !out_ready and saturate at 2^CNT_W-1; flush does not clear it.
REQ-023 occupancy SHALL be registered and always equal the count of valid entries.
REQ-024 out_data SHALL be driven only from registers (no combinational path from in_data).

Reset
REQ-025 On rst edge: out_valid=0, out_data=NOP_PAYLOAD, skid entry invalid and NOP_PAYLOAD, discarded=0, occupancy=0, stall_cnt=0.
REQ-026 in_ready SHALL be 1 in the first cycle after reset deasserts; rst SHALL override flush_i and all transfers, including mid-stall.

Configuration
REQ-027 Macro PIPE_STAGE_SKID_EN SHALL, when defined, add a second (skid) entry; when undefined, stage is single-entry per REQ-017.
REQ-028 With PIPE_STAGE_SKID_EN: in_ready SHALL be registered and equal !skid_valid; no combinational path out_ready->in_ready.
REQ-029 With PIPE_STAGE_SKID_EN: input transfer while main valid and !out_ready SHALL write skid (occupancy 2).
REQ-030 With PIPE_STAGE_SKID_EN: on out_ready with skid valid, main SHALL load skid and skid SHALL load in_data if transferring, else empty; order preserved.
REQ-031 With PIPE_STAGE_SKID_EN: simultaneous input and output transfer with occupancy 1 SHALL keep occupancy 1 with main=new in_data.

Verification
REQ-032 Reset then in_valid=1, in_data=0xA5 continuous, out_ready=1 -> out_data=0xA5, out_valid=1 one cycle later, stream 1/cycle, stall_cnt=0.
REQ-033 Payload 0x11 held with out_ready=0 for 5 cycles -> out_data stays 0x11, stall_cnt=5, no-skid in_ready=0 throughout.
REQ-034 Occupancy 1, flush_i=1 with in_valid=1 data 0x22 -> next cycle out_valid=0, out_data=NOP_PAYLOAD, discarded=1, 0x22 never appears.
REQ-035 Skid build: push 0x01,0x02 while out_ready=0 -> occupancy=2, in_ready=0; out_ready=1 -> outputs 0x01 then 0x02 in order.
REQ-036 stall_cnt with CNT_W=4, 20 stalled cycles -> stall_cnt=15 saturated; rst asserted during stall -> all outputs at reset values next cycle.
REQ-037 in_valid=0 with stage empty, out_ready=1 -> out_valid=0, out_data=NOP_PAYLOAD, occupancy=0 (bubble insertion).
